// File: rtl/sdram_write_burst.sv
// rtl/sdram_write_burst.sv - SDRAM write engine splitting one request into page-bounded bursts
// Optional macro SDRAM_WR_DQM_EN adds byte-mask ports wr_dqm / wr_sdram_dqm.
module sdram_write_burst #(
  parameter int DATA_W = 16,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int LEN_W  = 10,
  parameter int TRCD   = 2,
  parameter int TWR    = 2,
  parameter int TRP    = 2
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst_n,
  input  logic                            init_end,
  input  logic                            wr_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_addr,
  input  logic [LEN_W-1:0]                wr_bst_len,
  input  logic [DATA_W-1:0]               wr_data,
`ifdef SDRAM_WR_DQM_EN
  input  logic [DATA_W/8-1:0]             wr_dqm,
  output logic [DATA_W/8-1:0]             wr_sdram_dqm,
`endif
  output logic                            wr_ack,
  output logic                            wr_end,
  output logic                            wr_busy,
  output logic                            wr_sdram_en,
  output logic [3:0]                      wr_sdram_cmd,
  output logic [BANK_W-1:0]               wr_sdram_bank,
  output logic [ROW_W-1:0]                wr_sdram_addr,
  output logic [DATA_W-1:0]               wr_sdram_data
);

  localparam int A_W   = BANK_W + ROW_W + COL_W;
  localparam int SEG_W = COL_W + 1;
  localparam int CW    = (LEN_W > SEG_W) ? LEN_W : SEG_W;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [CW-1:0]    PAGE_WORDS = CW'(2 ** COL_W);
  localparam logic [ROW_W-1:0] PRE_ADDR   = ROW_W'(1) << 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_TRCD,
    S_WR,
    S_DATA,
    S_TWR,
    S_PRE,
    S_TRP,
    S_END
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SEG_W-1:0]  cnt;
  logic [A_W-1:0]    cur_addr;
  logic [LEN_W-1:0]  rem;

  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [BANK_W-1:0] cur_bank;
  logic [CW-1:0]     page_left;
  logic [CW-1:0]     rem_ext;
  logic [CW-1:0]     seg_full;
  logic [SEG_W-1:0]  seg;
  logic              last_data;

  assign cur_col  = cur_addr[COL_W-1:0];
  assign cur_row  = cur_addr[COL_W +: ROW_W];
  assign cur_bank = cur_addr[COL_W+ROW_W +: BANK_W];

  // Segment never runs past the end of the open column page.
  assign page_left = PAGE_WORDS - CW'(cur_col);
  assign rem_ext   = CW'(rem);
  assign seg_full  = (rem_ext < page_left) ? rem_ext : page_left;
  assign seg       = seg_full[SEG_W-1:0];
  assign last_data = (cnt == seg - SEG_W'(1));

  always_comb begin
    state_nxt = state;
    wr_ack    = 1'b0;
    wr_end    = 1'b0;
    wr_busy   = 1'b1;
    case (state)
      S_IDLE: begin
        wr_busy = 1'b0;
        if (init_end && wr_en && (wr_bst_len != '0))
          state_nxt = S_ACT;
      end
      S_ACT:  state_nxt = S_TRCD;
      S_TRCD: if (cnt == SEG_W'(TRCD - 1)) state_nxt = S_WR;
      S_WR: begin
        wr_ack    = 1'b1;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        wr_ack = !last_data;
        if (last_data)
          state_nxt = S_TWR;
      end
      S_TWR:  if (cnt == SEG_W'(TWR - 1)) state_nxt = S_PRE;
      S_PRE:  state_nxt = S_TRP;
      S_TRP: begin
        if (cnt == SEG_W'(TRP - 1))
          state_nxt = (rem != '0) ? S_ACT : S_END;
      end
      S_END: begin
        wr_end    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // One counter serves every timed state; it restarts on each state change.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      cnt <= '0;
    else if ((state_nxt != state) || (state == S_IDLE))
      cnt <= '0;
    else
      cnt <= cnt + SEG_W'(1);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      cur_addr <= '0;
      rem      <= '0;
    end else if ((state == S_IDLE) && (state_nxt == S_ACT)) begin
      cur_addr <= wr_addr;
      rem      <= wr_bst_len;
    end else if ((state == S_DATA) && last_data) begin
      // Linear {bank,row,col} add: column overflow carries into row, then bank.
      cur_addr <= cur_addr + A_W'(seg);
      rem      <= rem - LEN_W'(seg);
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= '1;
      wr_sdram_addr <= '1;
      wr_sdram_en   <= 1'b0;
    end else begin
      wr_sdram_cmd  <= CMD_NOP;
      wr_sdram_bank <= '1;
      wr_sdram_addr <= '1;
      wr_sdram_en   <= wr_ack;
      case (state)
        S_ACT: begin
          wr_sdram_cmd  <= CMD_ACT;
          wr_sdram_bank <= cur_bank;
          wr_sdram_addr <= cur_row;
        end
        S_WR: begin
          wr_sdram_cmd  <= CMD_WR;
          wr_sdram_bank <= cur_bank;
          wr_sdram_addr <= ROW_W'(cur_col);
        end
        S_DATA: if (last_data) wr_sdram_cmd <= CMD_BST;
        S_PRE: begin
          wr_sdram_cmd  <= CMD_PRE;
          wr_sdram_bank <= cur_bank;
          wr_sdram_addr <= PRE_ADDR;
        end
        default: ;
      endcase
    end
  end

  assign wr_sdram_data = wr_sdram_en ? wr_data : '0;

`ifdef SDRAM_WR_DQM_EN
  assign wr_sdram_dqm = wr_sdram_en ? wr_dqm : '1;
`endif

endmodule
